// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 slice.
// Register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  function automatic logic is_addr_err(
    input logic [4:0] code
  );
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: pipeline-side bundle of the coprocessor-0.
// master = pipeline, slave = cp0_unit.
interface cp0_if #(
  parameter int NUM_HWINT = 6
);
  logic [4:0]           rd_addr;
  logic [4:0]           wr_addr;
  logic [31:0]          wr_data;
  logic                 we;
  logic [31:0]          exc_pc;
  logic                 exc_bd;
  logic [4:0]           exc_code;
  logic [31:0]          exc_badvaddr;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 eret;
  logic                 int_req;
  logic [31:0]          epc;
  logic [31:0]          rd_data;
  logic                 timer_irq;

  modport master (
    output rd_addr, wr_addr, wr_data, we,
    output exc_pc, exc_bd, exc_code,
    output exc_badvaddr, hw_int, eret,
    input  int_req, epc, rd_data, timer_irq
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, we,
    input  exc_pc, exc_bd, exc_code,
    input  exc_badvaddr, hw_int, eret,
    output int_req, epc, rd_data, timer_irq
  );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the TI latch.
// A Compare write clears TI even when Count matches that cycle.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count_i,
  input  logic        we_compare_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  // next state: writes beat increment, compare write beats match
  always_comb begin
    count_d   = we_count_i ? wr_data_i : count_q + 32'd1;
    compare_d = we_compare_i ? wr_data_i : compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (we_compare_i) ti_d = 1'b0;
  end

  // timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '1;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: SR/Cause/EPC/BadVAddr/PRId, interrupt and exception
// arbitration, and the single take request to the M stage.
module cp0_unit #(
  parameter int          NUM_HWINT  = 6,
  parameter bit          TIMER_EN   = 1'b1,
  parameter logic [31:0] PRID_VALUE = 32'h1234_5678
) (
  input logic clk,
  input logic reset,
  cp0_if.slave cp0
);
  import cp0_pkg::*;

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic        bd_q, bd_d;
  logic [5:0]  im_q, im_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;

  logic [5:0]  hw_pad, ip_next;
  logic        irq, exc, take, wr_en, ti;
  logic [31:0] count, compare, sr, cause, rd;

  if (TIMER_EN) begin : g_timer
    cp0_timer u_timer (
      .clk          (clk),
      .reset        (reset),
      .we_count_i   (wr_en && cp0.wr_addr == REG_COUNT),
      .we_compare_i (wr_en && cp0.wr_addr == REG_COMPARE),
      .wr_data_i    (cp0.wr_data),
      .count_o      (count),
      .compare_o    (compare),
      .ti_o         (ti)
    );
  end else begin : g_no_timer
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
  end

  // pending vector and take arbitration
  always_comb begin
    hw_pad = '0;
    hw_pad[NUM_HWINT-1:0] = cp0.hw_int;
    ip_next = hw_pad;
    ip_next[5] = hw_pad[5] | ti;
    irq = (|(ip_next & im_q)) & ie_q & ~exl_q;
    exc = (cp0.exc_code != EXC_INT) & ~exl_q;
    take = irq | exc;
    wr_en = cp0.we & ~take;
  end

  // next state: a take flushes any mtc0/eret alongside it
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    bd_d   = bd_q;
    im_d   = im_q;
    ip_d   = ip_next;
    code_d = code_q;
    epc_d  = epc_q;
    bva_d  = bva_q;
    if (take) begin
      exl_d  = 1'b1;
      code_d = irq ? EXC_INT : cp0.exc_code;
      bd_d   = cp0.exc_bd;
      epc_d  = {cp0.exc_pc[31:2], 2'b00}
             - (cp0.exc_bd ? 32'd4 : 32'd0);
      if (!irq && is_addr_err(cp0.exc_code))
        bva_d = cp0.exc_badvaddr;
    end else begin
      if (wr_en && cp0.wr_addr == REG_SR) begin
        im_d  = cp0.wr_data[SR_IM_LO +: 6];
        exl_d = cp0.wr_data[SR_EXL];
        ie_d  = cp0.wr_data[SR_IE];
      end
      if (wr_en && cp0.wr_addr == REG_EPC)
        epc_d = cp0.wr_data;
      if (cp0.eret) begin
        exl_d = 1'b0;
        bd_d  = 1'b0;
      end
    end
  end

  // architectural register state
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      bd_q   <= 1'b0;
      im_q   <= '0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
      bva_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      bd_q   <= bd_d;
      im_q   <= im_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
      bva_q  <= bva_d;
    end
  end

  // SR/Cause images and mfc0 read mux
  always_comb begin
    sr = '0;
    sr[SR_IM_LO +: 6] = im_q;
    sr[SR_EXL] = exl_q;
    sr[SR_IE]  = ie_q;
    cause = '0;
    cause[CAUSE_BD] = bd_q;
    cause[CAUSE_TI] = ti;
    cause[CAUSE_IP_LO +: 6]  = ip_q;
    cause[CAUSE_EXC_LO +: 5] = code_q;
    rd = '0;
    unique case (1'b1)
      cp0.rd_addr == REG_BADVADDR: rd = bva_q;
      cp0.rd_addr == REG_COUNT:    rd = count;
      cp0.rd_addr == REG_COMPARE:  rd = compare;
      cp0.rd_addr == REG_SR:       rd = sr;
      cp0.rd_addr == REG_CAUSE:    rd = cause;
      cp0.rd_addr == REG_EPC:      rd = epc_q;
      cp0.rd_addr == REG_PRID:     rd = PRID_VALUE;
      default:                     rd = '0;
    endcase
  end

  assign cp0.int_req   = take & ~reset;
  assign cp0.epc       = reset ? '0 : epc_q;
  assign cp0.timer_irq = ti & ~reset;
  assign cp0.rd_data   = rd;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed stimulus, architectural model compared
// every cycle, plus literal expectations from worked examples.
module tb_cp0_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_if #(.NUM_HWINT(6)) bus ();
  cp0_if #(.NUM_HWINT(2)) bus2 ();

  cp0_unit #(
    .NUM_HWINT(6), .TIMER_EN(1'b1),
    .PRID_VALUE(32'h1234_5678)
  ) dut (.clk(clk), .reset(reset), .cp0(bus));

  cp0_unit #(
    .NUM_HWINT(2), .TIMER_EN(1'b0),
    .PRID_VALUE(32'h1234_5678)
  ) dut2 (.clk(clk), .reset(reset), .cp0(bus2));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // architectural model: whole registers, spec rules
  bit          m_valid = 1'b0;
  logic [31:0] m_sr, m_epc, m_bva, m_cnt, m_cmp;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [5:0]  m_ip;

  function automatic logic [5:0] m_pend();
    return bus.hw_int | {m_ti, 5'b0};
  endfunction

  function automatic logic m_irq();
    return (|(m_pend() & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return (bus.exc_code != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bva;
      5'd9:  return m_cnt;
      5'd11: return m_cmp;
      5'd12: return m_sr;
      5'd13: return {m_bd, m_ti, 14'b0, m_ip, 3'b0, m_code, 2'b0};
      5'd14: return m_epc;
      5'd15: return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : mdl
    logic ir, ex, bd_n, ti_n;
    logic [31:0] sr_n, epc_n, bva_n, cnt_n, cmp_n;
    logic [4:0] code_n;
    if (reset) begin
      m_valid <= 1'b1;
      m_sr <= 32'h0; m_epc <= 32'h0; m_bva <= 32'h0;
      m_cnt <= 32'h0; m_cmp <= 32'hFFFF_FFFF;
      m_bd <= 1'b0; m_ti <= 1'b0; m_code <= 5'd0; m_ip <= 6'd0;
    end else begin
      ir = m_irq();
      ex = m_exc();
      sr_n = m_sr; epc_n = m_epc; bva_n = m_bva;
      bd_n = m_bd; code_n = m_code;
      cnt_n = m_cnt + 32'd1;
      cmp_n = m_cmp;
      ti_n = m_ti | (m_cnt == m_cmp);
      if (ir || ex) begin
        sr_n = m_sr | 32'd2;
        code_n = ir ? 5'd0 : bus.exc_code;
        bd_n = bus.exc_bd;
        epc_n = (bus.exc_pc & ~32'd3) - (bus.exc_bd ? 32'd4 : 32'd0);
        if (!ir && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
          bva_n = bus.exc_badvaddr;
      end else begin
        if (bus.we) begin
          case (bus.wr_addr)
            5'd9:  cnt_n = bus.wr_data;
            5'd11: begin cmp_n = bus.wr_data; ti_n = 1'b0; end
            5'd12: sr_n = bus.wr_data & 32'h0000_FC03;
            5'd14: epc_n = bus.wr_data;
            default: ;
          endcase
        end
        if (bus.eret) begin
          sr_n = sr_n & ~32'd2;
          bd_n = 1'b0;
        end
      end
      m_ip <= m_pend();
      m_sr <= sr_n; m_epc <= epc_n; m_bva <= bva_n;
      m_cnt <= cnt_n; m_cmp <= cmp_n; m_ti <= ti_n;
      m_bd <= bd_n; m_code <= code_n;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      chk("m_int_req", bus.int_req, m_irq() | m_exc());
      chk("m_epc", bus.epc, m_epc);
      chk("m_timer_irq", bus.timer_irq, m_ti);
      chk("m_rd_data", bus.rd_data, m_read(bus.rd_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string nm, input logic [4:0] a,
                       input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic eret_cycle();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  logic found;

  initial begin
    reset = 1'b1;
    bus.rd_addr = 5'd12; bus.wr_addr = 5'd0; bus.wr_data = '0;
    bus.we = 1'b0; bus.exc_pc = '0; bus.exc_bd = 1'b0;
    bus.exc_code = 5'd0; bus.exc_badvaddr = '0;
    bus.hw_int = '0; bus.eret = 1'b0;
    bus2.rd_addr = 5'd13; bus2.wr_addr = 5'd0; bus2.wr_data = '0;
    bus2.we = 1'b0; bus2.exc_pc = '0; bus2.exc_bd = 1'b0;
    bus2.exc_code = 5'd0; bus2.exc_badvaddr = '0;
    bus2.hw_int = 2'b11; bus2.eret = 1'b0;
    #1;
    chk("rst_int_req", bus.int_req, 0);
    chk("rst_timer_irq", bus.timer_irq, 0);
    chk("rst_epc", bus.epc, 0);
    tick();
    tick();
    reset = 1'b0;

    // interrupt taken
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_0401;
    tick();
    bus.we = 1'b0;
    probe("sr_write", 5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.exc_pc = 32'h0000_3008;
    #1;
    chk("irq_req", bus.int_req, 1);
    tick();
    chk("irq_epc", bus.epc, 32'h0000_3008);
    probe("irq_cause", 5'd13, 32'h0000_0400);
    probe("irq_sr", 5'd12, 32'h0000_0403);
    chk("irq_masked", bus.int_req, 0);
    bus.hw_int = '0;
    eret_cycle();
    probe("eret_sr", 5'd12, 32'h0000_0401);

    // delay-slot exception
    bus.exc_code = 5'd12; bus.exc_bd = 1'b1; bus.exc_pc = 32'h0000_3010;
    #1;
    chk("ds_req", bus.int_req, 1);
    tick();
    bus.exc_code = 5'd0; bus.exc_bd = 1'b0;
    chk("ds_epc", bus.epc, 32'h0000_300C);
    probe("ds_cause", 5'd13, 32'h8000_0030);
    eret_cycle();
    probe("ds_eret_sr", 5'd12, 32'h0000_0401);
    probe("ds_eret_cause", 5'd13, 32'h0000_0030);

    // address error, then a non-address exception
    bus.exc_code = 5'd4; bus.exc_badvaddr = 32'h0000_0003;
    bus.exc_pc = 32'h0000_3020;
    tick();
    bus.exc_code = 5'd0;
    probe("ade_bva", 5'd8, 32'h0000_0003);
    probe("ade_cause", 5'd13, 32'h0000_0010);
    eret_cycle();
    bus.exc_code = 5'd10; bus.exc_badvaddr = 32'h0000_FFFF;
    tick();
    bus.exc_code = 5'd0;
    probe("ri_bva", 5'd8, 32'h0000_0003);
    probe("ri_cause", 5'd13, 32'h0000_0028);
    eret_cycle();
    probe("prid", 5'd15, 32'h1234_5678);
    probe("unused_idx", 5'd3, 32'h0);

    // timer
    bus.we = 1'b1;
    bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_8001; tick();
    bus.wr_addr = 5'd9;  bus.wr_data = 32'h0;         tick();
    bus.wr_addr = 5'd11; bus.wr_data = 32'h5;         tick();
    bus.we = 1'b0;
    bus.rd_addr = 5'd9;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.timer_irq) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("ti_seen", found, 1);
    chk("ti_count", bus.rd_data, 32'h6);
    chk("ti_int_req", bus.int_req, 1);
    tick();
    bus.we = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 32'hFFFF_FFFF;
    tick();
    bus.we = 1'b0;
    chk("ti_cleared", bus.timer_irq, 0);
    eret_cycle();

    // take + mtc0 EPC
    bus.exc_code = 5'd12; bus.exc_pc = 32'h0000_3040;
    bus.we = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'h0000_DEAD;
    tick();
    bus.exc_code = 5'd0; bus.we = 1'b0;
    chk("take_mtc0_epc", bus.epc, 32'h0000_3040);
    eret_cycle();

    // take + eret
    bus.exc_code = 5'd12; bus.eret = 1'b1;
    tick();
    bus.exc_code = 5'd0; bus.eret = 1'b0;
    probe("take_eret_sr", 5'd12, 32'h0000_8003);
    eret_cycle();

    // interrupt and exception together
    bus.hw_int = 6'b100000; bus.exc_code = 5'd12;
    bus.exc_pc = 32'h0000_3050;
    tick();
    bus.hw_int = '0; bus.exc_code = 5'd0;
    probe("irq_exc_cause", 5'd13, 32'h0000_8000);
    chk("irq_exc_epc", bus.epc, 32'h0000_3050);
    eret_cycle();

    // reset in the middle of a handler
    bus.exc_code = 5'd12; bus.exc_pc = 32'h0000_3060;
    tick();
    bus.exc_code = 5'd0;
    probe("pre_rst_sr", 5'd12, 32'h0000_8003);
    reset = 1'b1;
    tick();
    probe("mid_rst_sr", 5'd12, 32'h0);
    chk("mid_rst_epc", bus.epc, 32'h0);
    chk("mid_rst_int_req", bus.int_req, 0);
    reset = 1'b0;
    tick();

    // reduced-parameter instance
    bus2.rd_addr = 5'd13;
    #1;
    chk("p2_ip_hi", {28'h0, bus2.rd_data[15:12]}, 32'h0);
    chk("p2_cause", bus2.rd_data, 32'h0000_0C00);
    bus2.rd_addr = 5'd9;
    #1;
    chk("p2_count", bus2.rd_data, 32'h0);
    bus2.rd_addr = 5'd11;
    #1;
    chk("p2_compare", bus2.rd_data, 32'h0);
    chk("p2_timer_irq", bus2.timer_irq, 0);
    chk("p2_int_req", bus2.int_req, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
